// File: rtl/sprite_seq_pkg.sv
// sprite_seq_pkg: shared types and screen constants for the sprite sequencer.
package sprite_seq_pkg;

  localparam int unsigned SCREEN_W = 240;
  localparam int unsigned SCREEN_H = 320;

  // Sequencer states:
  //   ST_IDLE      | waiting for a frame tick (or a pending one)
  //   ST_UPDATE    | move the current sprite, bounce off the screen edges
  //   ST_ISSUE     | wait for renderer ready, pulse draw
  //   ST_WAIT_ACK  | wait for the renderer to drop ready
  //   ST_WAIT_DONE | wait for the renderer to finish, then next sprite or idle
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_UPDATE    = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

  // dx/dy are two's-complement velocities stored as raw 4-bit fields.
  typedef struct packed {
    logic [7:0] x;
    logic [8:0] y;
    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] rom;
  } sprite_t;

endpackage

// File: rtl/sprite_sequencer_tick_divider.sv
// tick_divider: free-running divider giving a one-cycle strobe every
// CLOCK_FREQ/TICK_HZ cycles. Cleared by the synchronous reset.
module tick_divider #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned TICK_HZ    = 10
) (
  input  logic clock_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned PERIOD   = (CLOCK_FREQ / TICK_HZ > 1) ? (CLOCK_FREQ / TICK_HZ) : 2;
  localparam int unsigned CNT_W    = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // wrap the count at the end of each tick period
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  // divider count register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/sprite_sequencer.sv
// sprite_sequencer: keeps a small sprite table, moves every sprite once per
// frame tick (bouncing off the 240x320 screen edges) and issues one draw
// command per sprite to the renderer over the draw/ready handshake.
// Build option: define SPRITE_SEQ_ANIM_EN to step ROMId through ANIM_FRAMES
// images, one step per frame; otherwise ROMId is the sprite's base image.
module sprite_sequencer
  import sprite_seq_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ  = 50000000,
  parameter int unsigned TICK_HZ     = 10,
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPRITE_W    = 20,
  parameter int unsigned SPRITE_H    = 20,
  parameter int unsigned ANIM_FRAMES = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           ready,
  output logic                           draw,
  output logic [7:0]                     xOrigin,
  output logic [8:0]                     yOrigin,
  output logic [7:0]                     ROMId,
  output logic                           busy,
  input  logic                           cfgWe,
  input  logic [$clog2(NUM_SPRITES)-1:0] cfgIdx,
  input  logic [7:0]                     cfgX,
  input  logic [8:0]                     cfgY,
  input  logic [3:0]                     cfgDx,
  input  logic [3:0]                     cfgDy,
  input  logic [7:0]                     cfgRom,
  output logic [7:0]                     overrunCount
);

  localparam int unsigned IDX_W = $clog2(NUM_SPRITES);
  localparam logic [7:0]  X_MAX = 8'(SCREEN_W - SPRITE_W);
  localparam logic [8:0]  Y_MAX = 9'(SCREEN_H - SPRITE_H);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SPRITES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pend_q, pend_d;
  logic [7:0]        ovf_q, ovf_d;
  logic [7:0]        x_q, y_lo_unused_guard_q;
  logic [8:0]        y_q;
  logic [7:0]        rom_q;
  sprite_t           tbl_q [NUM_SPRITES];

  logic              tick;
  logic              last;
  sprite_t           cur;
  sprite_t           upd;
  logic signed [9:0]  xn;
  logic signed [10:0] yn;
  logic [7:0]        rom_next;

  tick_divider #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .TICK_HZ    (TICK_HZ)
  ) u_tick_divider (
    .clock_i (clock),
    .reset_i (reset),
    .tick_o  (tick)
  );

  assign last = (idx_q == IDX_LAST);

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and sprite index sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (enable && (tick || pend_q)) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (ready) begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (!ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (ready) begin
          if (last) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_UPDATE;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // handshake outputs decoded from the state
  always_comb begin
    draw = (state_q == ST_ISSUE) && ready;
    busy = (state_q != ST_IDLE);
  end

  // index register
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // tick bookkeeping: idle consumes or discards the pending tick; while busy
  // one tick is remembered and any further ones are counted as overruns
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (state_q == ST_IDLE) begin
      pend_d = 1'b0;
    end else if (tick) begin
      if (!pend_q) begin
        pend_d = 1'b1;
      end else if (ovf_q != 8'hFF) begin
        ovf_d = ovf_q + 8'd1;
      end
    end
  end

  // pending flag and overrun counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= 1'b0;
      ovf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // move the current sprite; a clamped axis also reverses its velocity
  always_comb begin
    cur = tbl_q[idx_q];
    upd = cur;
    xn  = $signed({2'b00, cur.x}) + $signed({{6{cur.dx[3]}}, cur.dx});
    yn  = $signed({2'b00, cur.y}) + $signed({{7{cur.dy[3]}}, cur.dy});
    if (xn[9]) begin
      upd.x  = 8'd0;
      upd.dx = ~cur.dx + 4'd1;
    end else if (xn > $signed({2'b00, X_MAX})) begin
      upd.x  = X_MAX;
      upd.dx = ~cur.dx + 4'd1;
    end else begin
      upd.x = xn[7:0];
    end
    if (yn[10]) begin
      upd.y  = 9'd0;
      upd.dy = ~cur.dy + 4'd1;
    end else if (yn > $signed({2'b00, Y_MAX})) begin
      upd.y  = Y_MAX;
      upd.dy = ~cur.dy + 4'd1;
    end else begin
      upd.y = yn[8:0];
    end
  end

`ifdef SPRITE_SEQ_ANIM_EN
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);

  logic [7:0] anim_q;
  logic       frame_done;

  assign frame_done = (state_q == ST_WAIT_DONE) && ready && last;

  // animation phase advances once per completed frame
  always_ff @(posedge clock) begin
    if (reset) begin
      anim_q <= '0;
    end else if (frame_done) begin
      anim_q <= (anim_q == ANIM_LAST) ? 8'd0 : anim_q + 8'd1;
    end
  end

  assign rom_next = upd.rom + anim_q;
`else
  assign rom_next = upd.rom;
`endif

  // sprite table: config writes only while idle, position/velocity write-back in update
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        tbl_q[i] <= '0;
      end
    end else if ((state_q == ST_IDLE) && cfgWe) begin
      tbl_q[cfgIdx] <= '{x: cfgX, y: cfgY, dx: cfgDx, dy: cfgDy, rom: cfgRom};
    end else if (state_q == ST_UPDATE) begin
      tbl_q[idx_q] <= upd;
    end
  end

  // draw command registers hold steady from update until the next update
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      rom_q <= '0;
    end else if (state_q == ST_UPDATE) begin
      x_q   <= upd.x;
      y_q   <= upd.y;
      rom_q <= rom_next;
    end
  end

  assign y_lo_unused_guard_q = '0;
  assign xOrigin      = x_q;
  assign yOrigin      = y_q;
  assign ROMId        = rom_q;
  assign overrunCount = ovf_q;

endmodule
